// File: rtl/interface_dht11.sv
// DHT11 single-wire master: start pulse, response/bit timing, checksum check,
// and publication of humidity/temperature words with pronto/erro strobes.
module interface_dht11 #(
    parameter int unsigned T_START  = 900000,
    parameter int unsigned T_LIMIAR = 2000,
    parameter int unsigned TIMEOUT  = 10000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        medir,
    inout  wire         dht_bus,
    output logic        ocupado,
    output logic        pronto,
    output logic        erro,
    output logic [15:0] umidade,
    output logic [15:0] temperatura,
    output logic [3:0]  db_estado
);

    localparam int unsigned SYNC = 2;
    localparam int unsigned SW   = $clog2(T_START + 1);
    localparam int unsigned WW   = $clog2(TIMEOUT + SYNC + 1);

    typedef enum logic [3:0] {
        StOcioso    = 4'd0,
        StInicio    = 4'd1,
        StLibera    = 4'd2,
        StRespBaixo = 4'd3,
        StRespAlto  = 4'd4,
        StBitBaixo  = 4'd5,
        StBitAlto   = 4'd6,
        StCheca     = 4'd7,
        StFim       = 4'd8,
        StErro      = 4'd15
    } estado_t;

    estado_t       estado;
    logic [SW-1:0] start_cnt;
    logic [WW-1:0] wait_cnt;
    logic [WW-1:0] high_cnt;
    logic [5:0]    bit_cnt;
    logic [39:0]   dados;
    logic          drive_low;

    logic bus_meta;
    logic bus_sync;
    logic bus_prev;

    assign dht_bus   = drive_low ? 1'b0 : 1'bz;
    assign db_estado = estado;

    always_ff @(posedge clock) begin
        if (reset) begin
            bus_meta <= 1'b1;
            bus_sync <= 1'b1;
            bus_prev <= 1'b1;
        end else begin
            bus_meta <= dht_bus;
            bus_sync <= bus_meta;
            bus_prev <= bus_sync;
        end
    end

    logic       rise;
    logic       fall;
    logic       start_done;
    logic       wait_expired;
    logic       libera_expired;
    logic       flushed;
    logic       bit_val;
    logic [7:0] soma;

    always_comb begin
        rise           = bus_sync & ~bus_prev;
        fall           = ~bus_sync & bus_prev;
        start_done     = (32'(start_cnt) + 32'd1) >= T_START;
        wait_expired   = (32'(wait_cnt) + 32'd1) >= TIMEOUT;
        // Right after release the synchronizer still holds the driven low, so
        // LIBERA ignores it for SYNC cycles and its timeout window is that much longer.
        flushed        = 32'(wait_cnt) >= SYNC;
        libera_expired = (32'(wait_cnt) + 32'd1) >= (TIMEOUT + SYNC);
        // high_cnt excludes the cycle in which the rising edge was seen.
        bit_val        = (32'(high_cnt) + 32'd1) >= T_LIMIAR;
        soma           = dados[39:32] + dados[31:24] + dados[23:16] + dados[15:8];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado      <= StOcioso;
            start_cnt   <= '0;
            wait_cnt    <= '0;
            high_cnt    <= '0;
            bit_cnt     <= '0;
            dados       <= '0;
            drive_low   <= 1'b0;
            ocupado     <= 1'b0;
            pronto      <= 1'b0;
            erro        <= 1'b0;
            umidade     <= '0;
            temperatura <= '0;
        end else begin
            pronto <= 1'b0;
            erro   <= 1'b0;
            unique case (estado)
                StOcioso: begin
                    if (medir) begin
                        estado    <= StInicio;
                        ocupado   <= 1'b1;
                        drive_low <= 1'b1;
                        start_cnt <= '0;
                    end
                end
                StInicio: begin
                    bit_cnt <= '0;
                    if (start_done) begin
                        estado    <= StLibera;
                        drive_low <= 1'b0;
                        wait_cnt  <= '0;
                    end else begin
                        start_cnt <= start_cnt + 1'b1;
                    end
                end
                StLibera: begin
                    if (flushed && !bus_sync) begin
                        estado   <= StRespBaixo;
                        wait_cnt <= '0;
                    end else if (libera_expired) begin
                        estado  <= StErro;
                        erro    <= 1'b1;
                        ocupado <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                StRespBaixo, StBitBaixo: begin
                    if (rise) begin
                        estado   <= (estado == StRespBaixo) ? StRespAlto : StBitAlto;
                        wait_cnt <= '0;
                        high_cnt <= '0;
                    end else if (wait_expired) begin
                        estado  <= StErro;
                        erro    <= 1'b1;
                        ocupado <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                StRespAlto: begin
                    if (fall) begin
                        estado   <= StBitBaixo;
                        wait_cnt <= '0;
                    end else if (wait_expired) begin
                        estado  <= StErro;
                        erro    <= 1'b1;
                        ocupado <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                StBitAlto: begin
                    if (fall) begin
                        dados    <= {dados[38:0], bit_val};
                        bit_cnt  <= bit_cnt + 1'b1;
                        wait_cnt <= '0;
                        estado   <= (bit_cnt == 6'd39) ? StCheca : StBitBaixo;
                    end else if (wait_expired) begin
                        estado  <= StErro;
                        erro    <= 1'b1;
                        ocupado <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        high_cnt <= high_cnt + 1'b1;
                    end
                end
                StCheca: begin
                    ocupado <= 1'b0;
                    if (soma == dados[7:0]) begin
                        estado      <= StFim;
                        pronto      <= 1'b1;
                        umidade     <= dados[39:24];
                        temperatura <= dados[23:8];
                    end else begin
                        estado <= StErro;
                        erro   <= 1'b1;
                    end
                end
                StFim, StErro: begin
                    estado <= StOcioso;
                end
                default: begin
                    estado <= StOcioso;
                end
            endcase
        end
    end

endmodule

// File: doc/interface_dht11.md
Name: interface_dht11

Overview:
Single-wire DHT11 master that sits inside tusca between the dht_bus pad and the temperature-level / fan / servo logic.
- On a measurement request it issues the start pulse and releases the bus.
- It then times the sensor's response and 40 data bits and verifies the checksum.
- It publishes humidity and temperature words with a one-cycle pronto strobe, or an erro strobe on timeout or bad checksum.

Parameters:
- T_START, 900000, cycles the bus is held low for the start pulse (18 ms at 50 MHz).
- T_LIMIAR, 2000, high-time threshold in cycles: high width ≥ T_LIMIAR decodes as 1, otherwise 0 (40 µs).
- TIMEOUT, 10000, maximum cycles spent waiting for any single bus edge before aborting (200 µs).

Ports:
- clock  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high
- medir  in  1  one-cycle request to start a measurement
- dht_bus  inout  1  open-drain: block drives 0 or 1'bz, never 1; external pull-up
- ocupado  out  1  high from accepted medir until pronto/erro
- pronto  out  1  one-cycle strobe: valid frame, outputs updated
- erro  out  1  one-cycle strobe: timeout or checksum mismatch
- umidade  out  16  {byte0, byte1} of last valid frame
- temperatura  out  16  {byte2, byte3} of last valid frame
- db_estado  out  4  state code for 7-seg debug

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - dht_bus released (z); ocupado=0, pronto=0, erro=0.
  - umidade=0, temperatura=0.
  - State OCIOSO; all counters 0.
  - Reset asserted mid-frame releases the bus on the next edge and discards partial data.
- Input path: dht_bus passes through a 2-FF synchronizer; all edge detection uses the synced value, so there is 2 cycles of latency, which is tolerated by the thresholds.
- States and encodings (db_estado):
  - OCIOSO(0): bus z. medir → INICIO, and ocupado rises the same edge. medir in any other state is ignored.
  - INICIO(1): drive 0 for T_START cycles → LIBERA.
  - LIBERA(2): bus z; wait for synced low → RESP_BAIXO.
  - RESP_BAIXO(3): wait for rising edge → RESP_ALTO.
  - RESP_ALTO(4): wait for falling edge → BIT_BAIXO.
  - BIT_BAIXO(5): wait for rising edge → BIT_ALTO; clear the high counter.
  - BIT_ALTO(6): count high cycles. On falling edge:
    - shift (count ≥ T_LIMIAR) into a 40-bit register, MSB first;
    - increment the bit counter;
    - if 40 bits are received → CHECA, else → BIT_BAIXO.
  - CHECA(7): compare (byte0+byte1+byte2+byte3) mod 256 with byte4. The sum uses an 8-bit wrap-around adder.
    - Match → FIM: load umidade/temperatura, pronto=1 for one cycle.
    - Mismatch → ERRO.
  - FIM(8) / ERRO(15): one cycle, then → OCIOSO. ocupado falls the cycle the strobe is high; outputs are unchanged on ERRO.
- Timeout: in states 2–6 a single edge-wait counter reloads on every transition. Reaching TIMEOUT → ERRO. This covers a missing sensor (bus stuck high) and a stuck-low bus.
- Bit counter: 6 bits, 0..40, cleared in INICIO. The frame ends only on the 40th falling edge, i.e. the sensor's trailing 50 µs low.
- pronto and erro are never high in the same cycle; exactly one of them fires per accepted medir.
- measured cycles = T_START + protocol time; typically about 4 ms after release.

Test Plan:
- Reset, then medir; sensor model responds with 80 µs low, 80 µs high, then frame 40'h123422026a (bit: 50 µs low + 27/70 µs high, trailing 50 µs low) → bus low for exactly 900000 cycles, pronto=1 one cycle, umidade=16'h1234, temperatura=16'h2202, erro=0.
- Frame 40'h2345aab2ab (checksum should be c4) → erro strobe, no pronto, umidade/temperatura keep 1234/2202.
- Frame 40'h2345aab2c4 → pronto, umidade=16'h2345, temperatura=16'haab2.
- No sensor response (bus stays pulled high after release) → erro exactly TIMEOUT+synchronizer cycles after entering LIBERA; bus released; ocupado=0 afterwards.
- medir pulsed again during BIT_ALTO, and reset asserted mid-frame → second medir ignored (single strobe). After reset: bus z, all outputs 0, db_estado=0, and a subsequent full frame decodes correctly.
- Boundary widths: high widths of T_LIMIAR-1 and T_LIMIAR cycles (after sync) → decode as 0 and 1 respectively.
